fadd_seq: RTL and testbench
===========================

Name: fadd_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit.
- Successor to the team's combinational single-precision adder. Adds generic exponent/mantissa widths, a subtract mode, round-to-nearest-even, exception flags, and valid/ready handshakes on input and output.
- Sits between operand-producing logic and result consumers in the FP datapath.
- Processes one operation at a time through a fixed 4-cycle FSM.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit not stored).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands.
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
- b  in  1+EXP_W+MAN_W  operand B.
- op_sub  in  1  0: y=a+b, 1: y=a-b (B sign inverted at capture).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- y  out  1+EXP_W+MAN_W  result.
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with y.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; y=0; flags=0.
  - Applies in any state, aborting an in-flight operation; the result is discarded.
- States: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a, b and op_sub, then go to ALIGN.
- ALIGN:
  - Unpack both operands and apply special-case and flush rules.
  - Swap so the larger-magnitude operand is first.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits (sticky = OR of all bits shifted past round).
  - A difference above MAN_W+3 leaves only sticky.
- ADD: add or subtract significands per effective sign; MAN_W+5 bit datapath.
- NORM:
  - On carry out, shift right 1 and increment the exponent (the bit shifted out ORs into sticky).
  - Otherwise shift left by the leading-zero count and decrement the exponent.
  - A zero result gives +0.
- ROUND:
  - Round-to-nearest-even using guard/round/sticky.
  - Mantissa overflow from rounding increments the exponent.
  - inexact = guard|round|sticky before rounding.
- DONE:
  - out_valid=1; y and flags held stable.
  - On out_ready, go to IDLE with out_valid=0 at the next edge.
- Latency: operands accepted at edge N give out_valid=1 after edge N+4.
- in_ready is 0 from ALIGN through DONE; no new operand is accepted while busy.
- Subnormals: inputs with exp=0 are treated as zero (sign kept). Results below the minimum normal flush to signed zero with underflow=1 and inexact=1.
- Exact cancellation (x + -x) gives +0 with no flags set.
- Overflow: a result exponent of all ones or more gives signed Inf with overflow=1 and inexact=1.
- Inf ± finite gives that Inf with no flags.
- Inf + (-Inf) gives canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0) with invalid=1.
- Any NaN input gives canonical qNaN; invalid=0.
- Special cases still take the full 4-cycle latency.
- in_valid in DONE is ignored; operands must be held until in_ready.

Test Plan:
- a=0x3FC00000 (1.5), b=0x40900000 (4.5), op_sub=0 -> y=0x40C00000, flags=0, out_valid exactly 4 edges after accept.
- a=0x411AB852, b=0x410AB852, op_sub=1 -> y=0x3F800000 (1.0), flags=0. Also a=0x410AB852, b=0xC10AB852, op_sub=0 -> y=0x00000000, flags=0.
- Rounding ties:
  - a=0x3F800000, b=0x33800000 -> y=0x3F800000, inexact=1 (tie rounds to even).
  - a=0x3F800001, b=0x33800000 -> y=0x3F800002, inexact=1.
- Exceptions:
  - a=0x7F7FFFFF, b=0x7F7FFFFF -> y=0x7F800000, overflow=1, inexact=1.
  - a=0x7F800000, b=0xFF800000 -> y=0x7FC00000, invalid=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: y, flags and out_valid stay stable; in_ready=0; a new in_valid pulse is not accepted.
  - Raise out_ready: IDLE on the next edge, then the next operand is accepted.
- Reset mid-operation:
  - Assert rst during ADD: next edge gives out_valid=0, y=0, flags=0, in_ready=1.
  - A following 1.5+4.5 completes normally with y=0x40C00000.

Source files
------------

// File: rtl/fadd_seq_if.sv
// Operand/result handshake bundle for the sequential FP adder.
// slave is the adder side; master is the producer/consumer side.
interface fadd_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, y, flags
    );

    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, y, flags
    );
endinterface

// File: rtl/fadd_seq.sv
// Multi-cycle floating-point add/subtract: one operation at a time through
// ALIGN/ADD/NORM/ROUND, round-to-nearest-even, subnormals flushed to zero.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ALIGN | unpack, special cases, swap, align smaller significand
// ADD   | add/subtract aligned significands
// NORM  | normalise, adjust exponent
// ROUND | round to nearest even, pack result and flags
// DONE  | result valid, waiting for out_ready
module fadd_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic      clk,
    input  logic      rst,
    fadd_seq_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int EW  = EXP_W + 2;          // signed headroom for normalisation
    localparam int LZW = $clog2(SW + 1);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_MAX = EW'((2**EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [W-1:0]           y_q;
    logic [3:0]             flags_q;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [SW-1:0]          big_q;
    logic [SW-1:0]          small_q;
    logic                   eff_sub_q;
    logic [SW:0]            sum_q;
    logic [SW-1:0]          norm_q;
    logic                   zero_q;
    logic                   spec_q;
    logic [W-1:0]           spec_y_q;
    logic [3:0]             spec_f_q;

    logic                   sa, sb, a_ge, sign_l;
    logic [EXP_W-1:0]       ea, eb, exp_l, exp_s, diff;
    logic [MAN_W-1:0]       fa, fb;
    logic [MAN_W:0]         siga, sigb, sig_l, sig_s;
    logic [2*SW-1:0]        wide;
    logic [SW-1:0]          small_d;
    logic                   a_nan, b_nan, a_inf, b_inf;
    logic                   spec_d;
    logic [W-1:0]           spec_y_d;
    logic [3:0]             spec_f_d;

    always_comb begin
        sa    = a_q[W-1];
        sb    = b_q[W-1];
        ea    = a_q[MAN_W +: EXP_W];
        eb    = b_q[MAN_W +: EXP_W];
        fa    = a_q[MAN_W-1:0];
        fb    = b_q[MAN_W-1:0];
        siga  = (ea == '0) ? '0 : {1'b1, fa};
        sigb  = (eb == '0) ? '0 : {1'b1, fb};
        a_ge  = {ea, siga} >= {eb, sigb};
        sign_l = a_ge ? sa : sb;
        exp_l = a_ge ? ea : eb;
        exp_s = a_ge ? eb : ea;
        sig_l = a_ge ? siga : sigb;
        sig_s = a_ge ? sigb : siga;
        diff  = exp_l - exp_s;
        wide  = {sig_s, 3'b000, SW'(0)} >> diff;
        if (32'(diff) > 32'(MAN_W + 3))
            small_d = {{(SW-1){1'b0}}, |sig_s};
        else
            small_d = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

        a_nan    = (&ea) & (|fa);
        b_nan    = (&eb) & (|fb);
        a_inf    = (&ea) & ~(|fa);
        b_inf    = (&eb) & ~(|fb);
        spec_d   = 1'b1;
        spec_y_d = QNAN;
        spec_f_d = 4'b0000;
        if (a_nan || b_nan)
            spec_f_d = 4'b0000;
        else if (a_inf && b_inf && (sa != sb))
            spec_f_d = 4'b1000;
        else if (a_inf)
            spec_y_d = a_q;
        else if (b_inf)
            spec_y_d = b_q;
        else
            spec_d = 1'b0;
    end

    logic [LZW-1:0] lzc;
    logic [SW-1:0]  shl;

    always_comb begin
        lzc = '0;
        for (int i = 0; i < SW; i++)
            if (sum_q[i]) lzc = LZW'(SW - 1 - i);
        shl = sum_q[SW-1:0] << lzc;
    end

    logic                 rnd_up, inexact;
    logic [MAN_W+1:0]     mant_r;
    logic signed [EW-1:0] exp_r;
    logic [MAN_W-1:0]     frac_r;
    logic [W-1:0]         round_y_d;
    logic [3:0]           round_f_d;

    always_comb begin
        inexact = |norm_q[2:0];
        rnd_up  = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        mant_r  = {1'b0, norm_q[SW-1:3]} + (MAN_W+2)'(rnd_up);
        exp_r   = exp_q + EW'(mant_r[MAN_W+1]);
        frac_r  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        if (zero_q) begin
            round_y_d = '0;
            round_f_d = 4'b0000;
        end else if (exp_r >= EXP_MAX) begin
            round_y_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_f_d = 4'b0101;
        end else if (exp_r <= 0) begin
            round_y_d = {sign_q, {(W-1){1'b0}}};
            round_f_d = 4'b0011;
        end else begin
            round_y_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
            round_f_d = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= {bus.b[W-1] ^ bus.op_sub, bus.b[W-2:0]};
                        in_ready_q <= 1'b0;
                        state_q    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_q    <= sign_l;
                    exp_q     <= EW'(exp_l);
                    big_q     <= {sig_l, 3'b000};
                    small_q   <= small_d;
                    eff_sub_q <= sa ^ sb;
                    spec_q    <= spec_d;
                    spec_y_q  <= spec_y_d;
                    spec_f_q  <= spec_f_d;
                    state_q   <= ADD;
                end
                ADD: begin
                    // swap guarantees big >= small, so subtraction never wraps
                    if (eff_sub_q)
                        sum_q <= {1'b0, big_q} - {1'b0, small_q};
                    else
                        sum_q <= {1'b0, big_q} + {1'b0, small_q};
                    state_q <= NORM;
                end
                NORM: begin
                    zero_q <= 1'b0;
                    if (sum_q[SW]) begin
                        norm_q <= {sum_q[SW:2], sum_q[1] | sum_q[0]};
                        exp_q  <= exp_q + EW'(1);
                    end else if (sum_q == '0) begin
                        norm_q <= '0;
                        zero_q <= 1'b1;
                    end else begin
                        norm_q <= shl;
                        exp_q  <= exp_q - EW'(lzc);
                    end
                    state_q <= ROUND;
                end
                ROUND: begin
                    y_q         <= spec_q ? spec_y_q : round_y_d;
                    flags_q     <= spec_q ? spec_f_q : round_f_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fadd_seq.sv
// Directed self-checking bench for fadd_seq in single precision.
module tb_fadd_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_seq_if #(.EXP_W(8), .MAN_W(23)) bus();
    fadd_seq #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] y;
        logic [3:0]  f;
    } vec_t;

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] y, output logic [3:0] f, output int lat);
        int waitc = 0;
        lat = 0;
        while (bus.in_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        bus.a = a; bus.b = b; bus.op_sub = sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        y = bus.y;
        f = bus.flags;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL reset_y: got %h expected 00000000", bus.y); end
        n_checks++; if (bus.flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
    endtask

    task automatic test_basic_add();
        logic [31:0] y; logic [3:0] f; int lat;
        run_op(32'h3FC00000, 32'h40900000, 1'b0, y, f, lat);
        n_checks++; if (y !== 32'h40C00000) begin n_fail++; $display("FAIL basic_y: got %h expected 40c00000", y); end
        n_checks++; if (f !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b expected 0000", f); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_add_sub();
        vec_t v[4];
        logic [31:0] y; logic [3:0] f; int lat;
        v[0] = '{32'h411AB852, 32'h410AB852, 1'b1, 32'h3F800000, 4'b0000};
        v[1] = '{32'h410AB852, 32'hC10AB852, 1'b0, 32'h00000000, 4'b0000};
        v[2] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        v[3] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].a, v[i].b, v[i].sub, y, f, lat);
            n_checks++; if (y !== v[i].y) begin n_fail++; $display("FAIL addsub_y[%0d]: got %h expected %h", i, y, v[i].y); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL addsub_flags[%0d]: got %b expected %b", i, f, v[i].f); end
        end
    endtask

    task automatic test_rounding();
        vec_t v[3];
        logic [31:0] y; logic [3:0] f; int lat;
        v[0] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        v[1] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        v[2] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].a, v[i].b, v[i].sub, y, f, lat);
            n_checks++; if (y !== v[i].y) begin n_fail++; $display("FAIL round_y[%0d]: got %h expected %h", i, y, v[i].y); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL round_flags[%0d]: got %b expected %b", i, f, v[i].f); end
        end
    endtask

    task automatic test_exceptions();
        vec_t v[6];
        logic [31:0] y; logic [3:0] f; int lat;
        v[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        v[1] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        v[2] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        v[3] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
        v[4] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011};
        v[5] = '{32'h3F800000, 32'hFFFFFFFF, 1'b0, 32'h7FC00000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].sub, y, f, lat);
            n_checks++; if (y !== v[i].y) begin n_fail++; $display("FAIL exc_y[%0d]: got %h expected %h", i, y, v[i].y); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL exc_flags[%0d]: got %b expected %b", i, f, v[i].f); end
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL exc_latency[%0d]: got %0d expected 4", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] y; logic [3:0] f; int lat;
        int waitc = 0;
        int bad;
        bus.a = 32'h3FC00000; bus.b = 32'h40900000; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait_valid: got %b expected 1", bus.out_valid); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.a = 32'h40000000; bus.b = 32'h40000000; bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.y !== 32'h40C00000 || bus.flags !== 4'b0000 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b y=%h flags=%b ready=%b expected valid=1 y=40c00000 flags=0000 ready=0",
                         i, bus.out_valid, bus.y, bus.flags, bus.in_ready);
            end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold_cycles: got %0d bad cycles expected 0", bad); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_ignored_pulse: got %0d valid cycles expected 0", bad); end
        run_op(32'h40000000, 32'h40000000, 1'b0, y, f, lat);
        n_checks++; if (y !== 32'h40800000) begin n_fail++; $display("FAIL bp_next_y: got %h expected 40800000", y); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y; logic [3:0] f; int lat;
        int bad;
        bus.a = 32'h3FC00000; bus.b = 32'h40900000; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL midrst_y: got %h expected 00000000", bus.y); end
        n_checks++; if (bus.flags !== 4'h0) begin n_fail++; $display("FAIL midrst_flags: got %b expected 0000", bus.flags); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", bus.in_ready); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_discard: got %0d valid cycles expected 0", bad); end
        run_op(32'h3FC00000, 32'h40900000, 1'b0, y, f, lat);
        n_checks++; if (y !== 32'h40C00000) begin n_fail++; $display("FAIL midrst_after_y: got %h expected 40c00000", y); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_after_latency: got %0d expected 4", lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_sub    = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_basic_add();
        test_add_sub();
        test_rounding();
        test_exceptions();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
